vmerge_pipe: RTL and testbench
==============================

VMERGE_PIPE -- requirements
Module: vmerge_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 64: lane data width in bits; multiple of 64.
REQ-002 Parameter ADDR_WIDTH, default 32: writeback address width.
REQ-003 Parameter LATENCY, default 6: pipeline stages from input to output; legal range 1..16.
REQ-004 Parameter MASK_WIDTH, default DATA_WIDTH/8: one mask bit per possible element.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-009 in_addr  input  ADDR_WIDTH  writeback address carried with the data.
REQ-010 in_sew  input  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
REQ-011 in_mode  input  2  0=VV merge, 1=VX merge, 2=MV (unmasked move), 3=reserved.
REQ-012 in_mask  input  MASK_WIDTH  per-element select bits, element index order.
REQ-013 in_vec0  input  DATA_WIDTH  source 0, the false operand.
REQ-014 in_vec1  input  DATA_WIDTH  source 1, the true operand in VV and MV modes.
REQ-015 in_scalar  input  64  scalar operand for VX mode.
REQ-016 out_valid  output  1  result present.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 out_addr  output  ADDR_WIDTH  address of the result.
REQ-019 out_vec  output  DATA_WIDTH  merged result.
REQ-020 out_busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-021 Element width is E = 8<<in_sew; element count is N = DATA_WIDTH/E; element k occupies bits [k*E+E-1 : k*E].
REQ-022 In VV mode, element k takes in_vec1 when in_mask[k]=1, else in_vec0.
REQ-023 In VX mode, element k takes the low E bits of in_scalar when in_mask[k]=1, else in_vec0; the scalar is replicated to every element.
REQ-024 In MV mode, every element takes in_vec1 and in_mask is ignored.
REQ-025 Reserved mode 3 behaves exactly as VV mode.
REQ-026 Mask bits at index N and above are ignored.
REQ-027 Pipeline enable: en = !out_valid || out_ready; all stages shift by one stage only when en=1.
REQ-028 in_ready = en, combinationally; no input is taken while en=0.
REQ-029 Merge selection is evaluated in stage 0; the remaining LATENCY-1 stages only delay the result.
REQ-030 Stall behaviour: while en=0, all stages hold their contents; out_vec and out_addr stay stable while out_valid=1 and out_ready=0.
REQ-031 A stage captures valid=0 with zero data and zero address when its upstream entry is invalid (bubble zeroing).
REQ-032 Bubbles are not collapsed during a stall.
REQ-033 With out_ready held high, a result appears exactly LATENCY cycles after acceptance, at a throughput of one result per cycle.
REQ-034 out_busy is the OR of the valid bits of all stages, including the output stage.
REQ-035 Ordering is strictly FIFO; no entry is ever dropped or duplicated.

Reset
REQ-036 While rst=1, every stage valid bit, data register and address register clears to 0 on the clock edge.
REQ-037 Immediately after reset, out_valid=0, out_vec=0, out_addr=0 and out_busy=0.
REQ-038 in_ready is 1 after reset, because out_valid=0.
REQ-039 Reset asserted mid-operation discards all in-flight entries; no result from before the reset is ever emitted.

Structure
REQ-040 Package vmerge_pkg holds the mode encodings (MODE_VV, MODE_VX, MODE_MV) and SEW encodings (SEW_8, SEW_16, SEW_32, SEW_64).
REQ-041 Combinational per-64-bit-lane selection is implemented in sub-module vmerge_lane, instantiated DATA_WIDTH/64 times with its mask slice.
REQ-042 The delay stages are a generate loop over LATENCY in vmerge_pipe itself.

Verification
REQ-043 VV test: sew=0, mask=0x0F, vec0=0x1111..11, vec1=0x2222..22, ready=1 -> after 6 cycles out_vec=0x1111111122222222.
REQ-044 VX test: sew=2, mask=0x02, scalar=0xDEADBEEFCAFEF00D, vec0=0 -> out_vec=0xCAFEF00D00000000.
REQ-045 MV test: sew=1, mask=0x00, vec1=0xABCD..., mode=2 -> out_vec=vec1 regardless of mask.
REQ-046 Backpressure test: stream 10 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 10 results arrive in order with correct addresses.
REQ-047 Reset test: assert rst with 4 entries in flight -> out_valid=0 and out_busy=0 next cycle, and none of the 4 entries is ever emitted.
REQ-048 Parameter sweep: LATENCY=1 and DATA_WIDTH=128 with sew=3, mask=0x2 -> upper 64 bits from vec1, lower 64 bits from vec0, one-cycle latency.

Source files
------------

// File: rtl/vmerge_pkg.sv
// vmerge_pkg: mode and element-width encodings shared by the merge pipeline
package vmerge_pkg;
   typedef enum logic [1:0] {
      MODE_VV  = 2'd0,
      MODE_VX  = 2'd1,
      MODE_MV  = 2'd2,
      MODE_RSV = 2'd3
   } mode_e;
   typedef enum logic [1:0] {
      SEW_8  = 2'd0,
      SEW_16 = 2'd1,
      SEW_32 = 2'd2,
      SEW_64 = 2'd3
   } sew_e;
   localparam int LANE_BITS = 64;
endpackage

// File: rtl/vmerge_lane.sv
// vmerge_lane: byte-granular merge of one 64-bit lane; byte b belongs to lane element b>>sew
module vmerge_lane
   import vmerge_pkg::*;
(
   input  logic [1:0]  sew,
   input  logic [1:0]  mode,
   input  logic [7:0]  mask,
   input  logic [63:0] vec0,
   input  logic [63:0] vec1,
   input  logic [63:0] scalar,
   output logic [63:0] res
);
   for (genvar b = 0; b < 8; b++) begin : byt
      localparam logic [2:0] BI = 3'(b);
      logic [2:0] ei;
      logic [2:0] si;
      logic       sel;
      logic [7:0] tv;
      assign ei  = BI >> sew;
      assign si  = BI & ~(3'b111 << sew);
      assign sel = (mode == MODE_MV) || mask[ei];
      assign tv  = (mode == MODE_VX) ? scalar[{si, 3'b000} +: 8] : vec1[b*8 +: 8];
      assign res[b*8 +: 8] = sel ? tv : vec0[b*8 +: 8];
   end
endmodule

// File: rtl/vmerge_pipe.sv
// vmerge_pipe: vector merge evaluated in stage 0, then delayed through a stallable valid pipeline
module vmerge_pipe
   import vmerge_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LATENCY    = 6,
   parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [1:0]            in_sew,
   input  logic [1:0]            in_mode,
   input  logic [MASK_WIDTH-1:0] in_mask,
   input  logic [DATA_WIDTH-1:0] in_vec0,
   input  logic [DATA_WIDTH-1:0] in_vec1,
   input  logic [63:0]           in_scalar,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_vec,
   output logic                  out_busy
);
   localparam int LANES = DATA_WIDTH / LANE_BITS;
   logic                  en;
   logic [DATA_WIDTH-1:0] merged;
   logic [LATENCY-1:0]    vld;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   for (genvar l = 0; l < LANES; l++) begin : lane
      logic [7:0] ms;
      assign ms = (in_sew == SEW_8)  ? in_mask[l*8 +: 8] :
                  (in_sew == SEW_16) ? {4'b0, in_mask[l*4 +: 4]} :
                  (in_sew == SEW_32) ? {6'b0, in_mask[l*2 +: 2]} :
                                       {7'b0, in_mask[l]};
      vmerge_lane u_lane (
         .sew    (in_sew),
         .mode   (in_mode),
         .mask   (ms),
         .vec0   (in_vec0[l*LANE_BITS +: LANE_BITS]),
         .vec1   (in_vec1[l*LANE_BITS +: LANE_BITS]),
         .scalar (in_scalar),
         .res    (merged[l*LANE_BITS +: LANE_BITS])
      );
   end
   for (genvar s = 0; s < LATENCY; s++) begin : stg
      logic                  v;
      logic [DATA_WIDTH-1:0] d;
      logic [ADDR_WIDTH-1:0] a;
      logic                  pv;
      logic [DATA_WIDTH-1:0] pd;
      logic [ADDR_WIDTH-1:0] pa;
      if (s == 0) begin : src
         assign pv = in_valid;
         assign pd = merged;
         assign pa = in_addr;
      end else begin : src
         assign pv = stg[s-1].v;
         assign pd = stg[s-1].d;
         assign pa = stg[s-1].a;
      end
      assign vld[s] = v;
      // shift on enable; a bubble from upstream lands as zero data and address
      always_ff @(posedge clk) begin
         if (rst) begin
            v <= 1'b0;
            d <= '0;
            a <= '0;
         end else if (en) begin
            v <= pv;
            d <= pv ? pd : '0;
            a <= pv ? pa : '0;
         end
      end
   end
   assign out_valid = stg[LATENCY-1].v;
   assign out_vec   = stg[LATENCY-1].d;
   assign out_addr  = stg[LATENCY-1].a;
   assign out_busy  = |vld;
endmodule

// File: tb/tb_vmerge_pipe.sv
// tb_vmerge_pipe: scoreboard bench for the merge pipeline, default and wide/LATENCY=1 builds
module tb_vmerge_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, out_busy;
   logic [31:0] in_addr, out_addr;
   logic [1:0]  in_sew, in_mode;
   logic [7:0]  in_mask;
   logic [63:0] in_vec0, in_vec1, in_scalar, out_vec;

   logic         in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_busy_w;
   logic [31:0]  in_addr_w, out_addr_w;
   logic [1:0]   in_sew_w, in_mode_w;
   logic [15:0]  in_mask_w;
   logic [127:0] in_vec0_w, in_vec1_w, out_vec_w;
   logic [63:0]  in_scalar_w;

   vmerge_pipe u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_sew(in_sew), .in_mode(in_mode), .in_mask(in_mask), .in_vec0(in_vec0), .in_vec1(in_vec1),
      .in_scalar(in_scalar), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_vec(out_vec), .out_busy(out_busy)
   );

   vmerge_pipe #(.DATA_WIDTH(128), .LATENCY(1)) u_wide (
      .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .in_addr(in_addr_w),
      .in_sew(in_sew_w), .in_mode(in_mode_w), .in_mask(in_mask_w), .in_vec0(in_vec0_w),
      .in_vec1(in_vec1_w), .in_scalar(in_scalar_w), .out_valid(out_valid_w),
      .out_ready(out_ready_w), .out_addr(out_addr_w), .out_vec(out_vec_w), .out_busy(out_busy_w)
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // element-by-element merge straight from the architectural rules
   function automatic logic [127:0] ref_merge(int dw, logic [1:0] sew, logic [1:0] mode,
                                              logic [15:0] mask, logic [127:0] v0,
                                              logic [127:0] v1, logic [63:0] sc);
      int e = 8 << sew;
      int n = dw / e;
      logic [127:0] r = '0;
      for (int k = 0; k < n; k++) begin
         bit sel;
         sel = (mode == 2'd2) || mask[k];
         for (int j = 0; j < e; j++)
            r[k*e+j] = sel ? ((mode == 2'd1) ? sc[j] : v1[k*e+j]) : v0[k*e+j];
      end
      return r;
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [63:0] d;
   } beat_t;
   beat_t q[$];
   logic [31:0] next_addr = 0;
   bit prev_stall = 0;
   logic [63:0] prev_vec;
   logic [31:0] prev_addr;
   int got_cnt = 0;

   task automatic step(bit v, bit r);
      logic [127:0] t;
      beat_t e;
      @(negedge clk);
      in_valid  = v;
      out_ready = r;
      in_addr   = next_addr;
      in_sew    = 2'($urandom);
      in_mode   = 2'($urandom);
      in_mask   = 8'($urandom);
      in_vec0   = {$urandom, $urandom};
      in_vec1   = {$urandom, $urandom};
      in_scalar = {$urandom, $urandom};
      #1;
      check("busy", out_busy, q.size() != 0);
      check("in_ready", in_ready, !out_valid || r);
      if (prev_stall) begin
         check("stall_vec", out_vec, prev_vec);
         check("stall_addr", out_addr, prev_addr);
      end
      if (out_valid && r) begin
         if (q.size() == 0) check("spurious", out_valid, 1'b0);
         else begin
            e = q.pop_front();
            check("addr", out_addr, e.a);
            check("vec", out_vec, e.d);
            got_cnt++;
         end
      end
      if (v && in_ready) begin
         t = ref_merge(64, in_sew, in_mode, {8'b0, in_mask}, {64'b0, in_vec0}, {64'b0, in_vec1}, in_scalar);
         q.push_back('{next_addr, t[63:0]});
         next_addr++;
      end
      prev_stall = out_valid && !r;
      prev_vec   = out_vec;
      prev_addr  = out_addr;
   endtask

   task automatic directed(string tag, logic [1:0] sew, logic [1:0] mode, logic [7:0] mask,
                           logic [63:0] v0, logic [63:0] v1, logic [63:0] sc, logic [63:0] exp);
      int c = 0;
      @(negedge clk);
      in_valid = 1; out_ready = 1; in_addr = 32'hA5A5_0000 + 32'(mode);
      in_sew = sew; in_mode = mode; in_mask = mask;
      in_vec0 = v0; in_vec1 = v1; in_scalar = sc;
      @(posedge clk);
      #1 in_valid = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!out_valid && c < 20);
      check({tag, "_latency"}, c, 6);
      check({tag, "_vec"}, out_vec, exp);
      check({tag, "_addr"}, out_addr, 32'hA5A5_0000 + 32'(mode));
   endtask

   task automatic wide(string tag, logic [1:0] sew, logic [1:0] mode, logic [15:0] mask,
                       logic [127:0] v0, logic [127:0] v1, logic [63:0] sc, logic [127:0] exp);
      @(negedge clk);
      in_valid_w = 1; in_addr_w = 32'($urandom);
      in_sew_w = sew; in_mode_w = mode; in_mask_w = mask;
      in_vec0_w = v0; in_vec1_w = v1; in_scalar_w = sc;
      @(posedge clk);
      #1;
      check({tag, "_valid"}, out_valid_w, 1'b1);
      check({tag, "_vec"}, out_vec_w, exp);
      check({tag, "_addr"}, out_addr_w, in_addr_w);
      in_valid_w = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] a, b;
      int k, base;
      in_valid = 0; out_ready = 0; in_addr = 0; in_sew = 0; in_mode = 0; in_mask = 0;
      in_vec0 = 0; in_vec1 = 0; in_scalar = 0;
      in_valid_w = 0; out_ready_w = 1; in_addr_w = 0; in_sew_w = 0; in_mode_w = 0; in_mask_w = 0;
      in_vec0_w = 0; in_vec1_w = 0; in_scalar_w = 0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_vec", out_vec, 64'h0);
      check("rst_out_addr", out_addr, 32'h0);
      check("rst_out_busy", out_busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_wide_valid", out_valid_w, 1'b0);
      check("rst_wide_busy", out_busy_w, 1'b0);
      rst = 0;

      directed("vv", 2'd0, 2'd0, 8'h0F, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h0, 64'h1111_1111_2222_2222);
      directed("vx", 2'd2, 2'd1, 8'h02, 64'h0, 64'h5555_5555_5555_5555,
               64'hDEAD_BEEF_CAFE_F00D, 64'hCAFE_F00D_0000_0000);
      directed("mv", 2'd1, 2'd2, 8'h00, 64'h0123_4567_89AB_CDEF, 64'hABCD_ABCD_ABCD_ABCD,
               64'h0, 64'hABCD_ABCD_ABCD_ABCD);
      directed("rsv", 2'd0, 2'd3, 8'h0F, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_2222_2222);

      got_cnt = 0;
      base = int'(next_addr);
      for (int i = 0; i < 30; i++)
         step(int'(next_addr) - base < 10, !(i >= 7 && i < 12));
      check("bp_count", got_cnt, 10);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      k = 0;
      while (q.size() > 0 && k < 100) begin
         step(0, 1);
         k++;
      end
      check("drain", q.size(), 0);

      repeat (4) step(1, 1);
      @(negedge clk);
      in_valid = 0;
      rst = 1;
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_busy", out_busy, 1'b0);
      rst = 0;
      q.delete();
      prev_stall = 0;
      repeat (12) step(0, 1);

      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      wide("w_mask2", 2'd3, 2'd0, 16'h0002, a, b, 64'h0, {b[127:64], a[63:0]});
      wide("w_hi_ignored", 2'd3, 2'd0, 16'hFFFE, a, b, 64'h0, {b[127:64], a[63:0]});
      for (int i = 0; i < 20; i++) begin
         logic [1:0]  s, m;
         logic [15:0] mk;
         logic [63:0] sc;
         s = 2'($urandom); m = 2'($urandom); mk = 16'($urandom); sc = {$urandom, $urandom};
         a = {$urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         wide("w_rand", s, m, mk, a, b, sc, ref_merge(128, s, m, mk, a, b, sc));
      end
      @(posedge clk);
      #1;
      check("w_idle_valid", out_valid_w, 1'b0);
      check("w_idle_busy", out_busy_w, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
